// File: rtl/store_write_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : store_write_buffer
//  Purpose  : Queues 64-bit store rows (base addr + LANES words) and drains
//             each row as LANES sequential word writes into data memory.
//  Option   : STORE_BUF_LANE_MASK_EN adds a per-row lane_mask (skip lanes).
//  Revision : 1.0  initial release
// ============================================================================
module store_write_buffer #(
  parameter int ADDR_W = 16,
  parameter int WORD_W = 16,
  parameter int LANES  = 4,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sw_enable,
  input  logic [ADDR_W-1:0]        mem_addr,
  input  logic [LANES*WORD_W-1:0]  data_to_mem,
`ifdef STORE_BUF_LANE_MASK_EN
  input  logic [LANES-1:0]         lane_mask,
`endif
  output logic                     buf_ready,
  input  logic                     dmem_ready,
  output logic                     dmem_we,
  output logic [ADDR_W-1:0]        dmem_addr,
  output logic [WORD_W-1:0]        dmem_wdata,
  output logic                     busy,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t              state, state_next;
  logic [LANE_W-1:0]   lane, lane_next;
  logic [LANE_W-1:0]   eff_lane;
  logic                found, more;
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    count_next;
  logic                push, pop;

  logic [ADDR_W-1:0]       addr_q [DEPTH];
  logic [LANES*WORD_W-1:0] data_q [DEPTH];
  logic [ADDR_W-1:0]       head_addr;
  logic [LANES*WORD_W-1:0] head_data;
  logic [LANES-1:0]        head_mask;

  assign buf_ready = (count != FULL);
  assign push      = sw_enable && buf_ready;
  assign busy      = (state != IDLE) || (count != '0);
  assign head_addr = addr_q[rd_ptr];
  assign head_data = data_q[rd_ptr];

  // Entry storage carries no reset: contents are only meaningful below count.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr] <= mem_addr;
      data_q[wr_ptr] <= data_to_mem;
    end
  end

`ifdef STORE_BUF_LANE_MASK_EN
  logic [LANES-1:0] mask_q [DEPTH];

  always_ff @(posedge clk) begin
    if (push) begin
      mask_q[wr_ptr] <= lane_mask;
    end
  end

  assign head_mask = mask_q[rd_ptr];
`else
  assign head_mask = '1;
`endif

  // First enabled lane at or above the lane counter, and whether any follow.
  always_comb begin
    found    = 1'b0;
    more     = 1'b0;
    eff_lane = '0;
    for (int i = 0; i < LANES; i++) begin
      if (head_mask[i] && (i >= int'(lane))) begin
        if (!found) begin
          found    = 1'b1;
          eff_lane = LANE_W'(i);
        end else begin
          more = 1'b1;
        end
      end
    end
  end

  // An entry with nothing left to write retires without waiting on memory.
  assign pop = (state == WRITE) && (!found || (dmem_ready && !more));

  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + CNT_W'(1);
    end else if (pop && !push) begin
      count_next = count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      state    <= IDLE;
      lane     <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (sw_enable && !buf_ready) begin
        overflow <= 1'b1;
      end
      count <= count_next;
      state <= state_next;
      lane  <= lane_next;
    end
  end

  always_comb begin
    state_next = state;
    lane_next  = lane;
    dmem_we    = 1'b0;
    dmem_addr  = '0;
    dmem_wdata = '0;
    case (state)
      IDLE: begin
        // A push on this edge is already in storage next cycle: no bubble.
        if (count_next != '0) begin
          state_next = WRITE;
          lane_next  = '0;
        end
      end
      WRITE: begin
        if (found) begin
          dmem_we    = 1'b1;
          dmem_addr  = head_addr + ADDR_W'(eff_lane);
          dmem_wdata = head_data[eff_lane*WORD_W +: WORD_W];
        end
        if (pop) begin
          lane_next  = '0;
          state_next = (count_next != '0) ? WRITE : IDLE;
        end else if (found && dmem_ready) begin
          lane_next = eff_lane + LANE_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        lane_next  = '0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: doc/store_write_buffer.md
Name: store_write_buffer

Overview:
- Downstream of the store controller/register-row stage.
- Accepts one 64-bit store row (four 16-bit core lanes) plus a 16-bit base address per `sw_enable` strobe and queues it in a small FIFO.
- Drains each queued row into the single-port 16-bit data memory as four sequential word writes at base+0..base+3.
- Decouples the one-cycle store strobe from memory write latency and back-pressure.

Parameters:
- ADDR_W, 16, data-memory address width.
- WORD_W, 16, width of one lane/word.
- LANES, 4, lanes per row; row width = LANES*WORD_W.
- DEPTH, 4, FIFO entries (power of two, >= 2).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- sw_enable  input  1  one-cycle store strobe; row and address valid this cycle.
- mem_addr  input  ADDR_W  base address of the row.
- data_to_mem  input  LANES*WORD_W  row data; lane i = bits [i*WORD_W +: WORD_W].
- buf_ready  output  1  high when FIFO not full (a strobe this cycle is accepted).
- dmem_ready  input  1  memory accepts the presented write this cycle.
- dmem_we  output  1  write request to data memory.
- dmem_addr  output  ADDR_W  write address.
- dmem_wdata  output  WORD_W  write data.
- busy  output  1  FIFO non-empty or drain in progress.
- overflow  output  1  sticky: a strobe arrived while full.
- count  output  $clog2(DEPTH)+1  registered FIFO occupancy.

Behaviour:
- Reset (async): FIFO pointers and count = 0, FSM = IDLE, lane counter = 0. Outputs `dmem_we`=0, `dmem_addr`=0, `dmem_wdata`=0, `busy`=0, `overflow`=0, `buf_ready`=1.
- A reset mid-drain discards all queued and partially written rows.
- Push:
  - On a rising edge with `sw_enable`=1 and `count`<DEPTH, write {`mem_addr`, `data_to_mem`} at the write pointer.
  - Write pointer advances mod DEPTH.
- Full:
  - `buf_ready` = (`count` != DEPTH), decoded from registered `count`.
  - A strobe while `count`==DEPTH is dropped and sets `overflow`, even if a pop occurs on the same edge.
  - `overflow` is cleared only by reset.
- FSM states: IDLE, WRITE.
  - IDLE: if `count`>0, go to WRITE with lane=0. The first `dmem_we` is visible the cycle after the push edge (one-cycle latency from an empty buffer).
  - WRITE: `dmem_we`=1, `dmem_addr` = head.base + lane (mod 2^ADDR_W, wraps 0xFFFF->0x0000), `dmem_wdata` = head lane[lane].
  - Outputs are combinational from the FSM, lane counter and FIFO head, and are stable while `dmem_ready`=0.
  - On an edge with `dmem_ready`=1: if lane < LANES-1, lane increments.
  - If lane == LANES-1: pop head, lane=0. Stay in WRITE if `count` after pop > 0 (back-to-back rows, no bubble), else go to IDLE.
- Lane order is strictly 0,1,2,3; one word per accepted cycle. A row takes LANES cycles minimum.
- Simultaneous push and pop: `count` unchanged. The pushed entry becomes a later head normally.
- Push into an empty FIFO during IDLE: no bypass; the write starts the next cycle.
- `busy` = (FSM != IDLE) | (`count` != 0).
- Memory write data is never modified; no read path exists in this block.

Optional Feature:
- Macro: STORE_BUF_LANE_MASK_EN.
- With the macro:
  - Adds input `lane_mask` [LANES-1:0], sampled with `sw_enable` and stored per entry.
  - During WRITE, lanes whose mask bit is 0 are skipped: the lane counter jumps to the next set bit in the same cycle without asserting `dmem_we`.
  - An entry with mask 0000 is popped one cycle after reaching the head, with no write.
  - Addresses still use base + lane index, so skipped lanes leave gaps.
- Without the macro: the port is absent and all lanes are always written.

Test Plan:
- Single row, `dmem_ready` held 1: strobe addr 0x0100, data 0x4444_3333_2222_1111 -> next four cycles write (0x0100,0x1111), (0x0101,0x2222), (0x0102,0x3333), (0x0103,0x4444), then `busy`=0.
- Back-pressure: same row, `dmem_ready` low for 3 cycles during lane 1 -> `dmem_addr`=0x0101 and `dmem_wdata`=0x2222 held stable for those cycles; total 7 cycles, order intact.
- Fill and overflow: `dmem_ready`=0 and five consecutive strobes -> `count`=4, `buf_ready`=0, 5th row dropped, `overflow`=1. Release `dmem_ready` -> 16 writes, then `count`=0.
- Address wrap: base 0xFFFE -> writes at 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Reset mid-drain: assert `rst` during lane 2 of a row with 2 rows queued -> `dmem_we`=0 immediately; `count`=0 and `overflow`=0 after release; no further writes.
- STORE_BUF_LANE_MASK_EN: mask 0b1010 at base 0x0200 -> only (0x0201, lane1) and (0x0203, lane3) written. Mask 0b0000 -> entry popped with no `dmem_we`.
